// File: rtl/bus_split_arbiter_pkg.sv
// bus_arb_pkg: shared state, owner encodings and defaults for the split-transaction bus arbiter
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT1, GNT2, SPLIT_GNT} arb_state_t;
  typedef enum logic [1:0] {OWNER_NONE = 2'd0, OWNER_INIT1 = 2'd1, OWNER_INIT2 = 2'd2} owner_t;
  localparam int DEFAULT_TIMEOUT = 4096;
endpackage

// File: rtl/bus_split_arbiter_watchdog.sv
// bus_arb_watchdog: grant-hold counter that flags expiry on the last permitted cycle
module bus_arb_watchdog
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
  assign expire = (TIMEOUT_CYCLES != 0) && en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/bus_split_arbiter.sv
// bus_split_arbiter: two-initiator bus arbiter with split-transaction parking and grant watchdog
module bus_split_arbiter
  import bus_arb_pkg::*;
#(
  parameter logic ROUND_ROBIN = 1'b1,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init1_req,
  input  logic       init2_req,
  input  logic       split_ack,
  input  logic       split_req,
  output logic       init1_grant,
  output logic       init2_grant,
  output logic       init1_split_ack,
  output logic       init2_split_ack,
  output logic       split_grant,
  output logic [1:0] bus_owner,
  output logic       split_pending,
  output logic       timeout_err
);
  arb_state_t state, state_nxt;
  owner_t parked, park_nxt;
  logic pend_nxt, ptr, ptr_nxt, mask1, mask2, mask1_nxt, mask2_nxt;
  logic ack1_nxt, ack2_nxt, to_nxt, expire, e1, e2, cur_req;
  bus_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_wd (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state_nxt != state),
    .en(state != IDLE),
    .expire(expire)
  );
  assign e1 = init1_req && !mask1 && parked != OWNER_INIT1;
  assign e2 = init2_req && !mask2 && parked != OWNER_INIT2;
  assign cur_req = (state == GNT1) ? init1_req : init2_req;
  always_comb begin
    state_nxt = state;
    pend_nxt = split_pending;
    park_nxt = parked;
    ptr_nxt = ptr;
    mask1_nxt = mask1 & init1_req;
    mask2_nxt = mask2 & init2_req;
    ack1_nxt = 1'b0;
    ack2_nxt = 1'b0;
    to_nxt = 1'b0;
    case (state)
      IDLE:
        if (split_req && split_pending) state_nxt = SPLIT_GNT;
        else if (e1 && (!e2 || !ROUND_ROBIN || !ptr)) state_nxt = GNT1;
        else if (e2) state_nxt = GNT2;
      GNT1, GNT2:
        if (expire) begin
          state_nxt = IDLE;
          to_nxt = 1'b1;
          mask1_nxt = mask1_nxt | (state == GNT1);
          mask2_nxt = mask2_nxt | (state == GNT2);
        end else if (split_ack && !split_pending) begin
          state_nxt = IDLE;
          pend_nxt = 1'b1;
          park_nxt = (state == GNT1) ? OWNER_INIT1 : OWNER_INIT2;
          ack1_nxt = state == GNT1;
          ack2_nxt = state == GNT2;
        end else if (!cur_req) begin
          state_nxt = IDLE;
          ptr_nxt = state == GNT1;
        end
      default:
        if (expire || !split_req) begin
          state_nxt = IDLE;
          pend_nxt = 1'b0;
          park_nxt = OWNER_NONE;
          to_nxt = expire;
          mask1_nxt = mask1_nxt | (expire && parked == OWNER_INIT1);
          mask2_nxt = mask2_nxt | (expire && parked == OWNER_INIT2);
        end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      parked <= OWNER_NONE;
      split_pending <= 1'b0;
      ptr <= 1'b0;
      mask1 <= 1'b0;
      mask2 <= 1'b0;
      init1_split_ack <= 1'b0;
      init2_split_ack <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      parked <= park_nxt;
      split_pending <= pend_nxt;
      ptr <= ptr_nxt;
      mask1 <= mask1_nxt;
      mask2 <= mask2_nxt;
      init1_split_ack <= ack1_nxt;
      init2_split_ack <= ack2_nxt;
      timeout_err <= to_nxt;
    end
  assign split_grant = state == SPLIT_GNT;
  assign init1_grant = (state == GNT1) || (split_grant && parked == OWNER_INIT1);
  assign init2_grant = (state == GNT2) || (split_grant && parked == OWNER_INIT2);
  assign bus_owner = init1_grant ? OWNER_INIT1 : init2_grant ? OWNER_INIT2 : OWNER_NONE;
endmodule

// File: tb/tb_bus_split_arbiter.sv
// tb_bus_split_arbiter: directed and random checks of round-robin and fixed-priority arbiters against a transaction-level model
module tb_bus_split_arbiter;
  localparam int T = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init1_req = 1'b0, init2_req = 1'b0, split_ack = 1'b0, split_req = 1'b0;
  logic [1:0] g1, g2, a1, a2, sg, sp, to;
  logic [1:0] own [2];
  int n_chk = 0, n_fail = 0;
  int m_owner [2], m_park [2], m_held [2];
  bit m_sg [2], m_pri2 [2], m_to [2];
  bit [2:0] m_mask [2], m_ack [2];
  always #5 clk = ~clk;
  bus_split_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(T)) dut_rr (
    .clk(clk), .rst_n(rst_n), .init1_req(init1_req), .init2_req(init2_req),
    .split_ack(split_ack), .split_req(split_req), .init1_grant(g1[0]), .init2_grant(g2[0]),
    .init1_split_ack(a1[0]), .init2_split_ack(a2[0]), .split_grant(sg[0]),
    .bus_owner(own[0]), .split_pending(sp[0]), .timeout_err(to[0])
  );
  bus_split_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(T)) dut_fx (
    .clk(clk), .rst_n(rst_n), .init1_req(init1_req), .init2_req(init2_req),
    .split_ack(split_ack), .split_req(split_req), .init1_grant(g1[1]), .init2_grant(g2[1]),
    .init1_split_ack(a1[1]), .init2_split_ack(a2[1]), .split_grant(sg[1]),
    .bus_owner(own[1]), .split_pending(sp[1]), .timeout_err(to[1])
  );
  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0; m_park[k] = 0; m_held[k] = 0;
      m_sg[k] = 0; m_pri2[k] = 0; m_to[k] = 0; m_mask[k] = '0; m_ack[k] = '0;
    end
  endtask
  task automatic model_step(input int k, input bit rr);
    bit [2:0] req, e;
    int o;
    req = {init2_req, init1_req, 1'b0};
    o = m_owner[k];
    e = '0;
    for (int i = 1; i <= 2; i++) e[i] = req[i] && m_park[k] != i && !m_mask[k][i];
    m_mask[k] &= req;
    m_ack[k] = '0;
    m_to[k] = 0;
    if (o == 0) begin
      if (split_req && m_park[k] != 0) begin m_owner[k] = m_park[k]; m_sg[k] = 1; end
      else if (e[1] && e[2]) m_owner[k] = (rr && m_pri2[k]) ? 2 : 1;
      else if (e[1]) m_owner[k] = 1;
      else if (e[2]) m_owner[k] = 2;
      m_held[k] = 0;
    end else if (m_held[k] == T - 1) begin
      m_mask[k][o] = 1'b1;
      m_to[k] = 1;
      if (m_sg[k]) m_park[k] = 0;
      m_owner[k] = 0; m_sg[k] = 0;
    end else if (m_sg[k]) begin
      if (!split_req) begin m_owner[k] = 0; m_sg[k] = 0; m_park[k] = 0; end
      else m_held[k]++;
    end else if (split_ack && m_park[k] == 0) begin
      m_park[k] = o; m_ack[k][o] = 1'b1; m_owner[k] = 0;
    end else if (!req[o]) begin
      m_pri2[k] = (o == 1); m_owner[k] = 0;
    end else m_held[k]++;
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("init1_grant[%0d]", k), {1'b0, g1[k]}, 2'(m_owner[k] == 1));
      check($sformatf("init2_grant[%0d]", k), {1'b0, g2[k]}, 2'(m_owner[k] == 2));
      check($sformatf("bus_owner[%0d]", k), own[k], 2'(m_owner[k]));
      check($sformatf("split_grant[%0d]", k), {1'b0, sg[k]}, 2'(m_sg[k]));
      check($sformatf("split_pending[%0d]", k), {1'b0, sp[k]}, 2'(m_park[k] != 0));
      check($sformatf("init1_split_ack[%0d]", k), {1'b0, a1[k]}, 2'(m_ack[k][1]));
      check($sformatf("init2_split_ack[%0d]", k), {1'b0, a2[k]}, 2'(m_ack[k][2]));
      check($sformatf("timeout_err[%0d]", k), {1'b0, to[k]}, 2'(m_to[k]));
    end
  endtask
  task automatic cyc(input bit r1, input bit r2, input bit sa, input bit sr, input int n);
    for (int i = 0; i < n; i++) begin
      init1_req = r1; init2_req = r2; split_ack = sa; split_req = sr;
      @(posedge clk);
      model_step(0, 1'b1);
      model_step(1, 1'b0);
      @(negedge clk);
      check_all();
    end
  endtask
  initial begin
    bit r1, r2, sr;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 1);
    check("first_grant", {1'b0, g1[0]}, 2'd1);
    check("first_owner", own[0], 2'd1);
    cyc(1, 0, 0, 0, 4);
    cyc(0, 0, 0, 0, 1);
    check("release_grant", {1'b0, g1[0]}, 2'd0);
    for (int r = 0; r < 4; r++) begin
      cyc(1, 1, 0, 0, 4);
      cyc(0, 0, 0, 0, 1);
    end
    cyc(0, 1, 0, 0, 2);
    cyc(0, 1, 1, 0, 1);
    check("split_ack_pulse", {1'b0, a2[0]}, 2'd1);
    check("split_pending_set", {1'b0, sp[0]}, 2'd1);
    cyc(1, 1, 0, 0, 3);
    check("init1_while_parked", {1'b0, g1[0]}, 2'd1);
    cyc(1, 1, 1, 0, 1);
    cyc(1, 1, 0, 1, 3);
    check("no_preempt", {1'b0, sg[0]}, 2'd0);
    cyc(0, 1, 0, 1, 2);
    check("split_gnt_owner", own[0], 2'd2);
    cyc(0, 1, 0, 1, 2);
    cyc(0, 0, 0, 0, 2);
    check("pending_cleared", {1'b0, sp[0]}, 2'd0);
    cyc(0, 1, 0, 0, 2);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 1);
    check("split_beats_req", {1'b0, sg[1]}, 2'd1);
    cyc(1, 0, 0, 1, 2);
    cyc(1, 0, 0, 0, 2);
    check("init1_after_split", {1'b0, g1[1]}, 2'd1);
    cyc(1, 0, 0, 0, 20);
    check("masked_after_timeout", {1'b0, g1[0]}, 2'd0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 3);
    r1 = 0; r2 = 0; sr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r1 = ~r1;
      if ($urandom_range(0, 3) == 0) r2 = ~r2;
      if ($urandom_range(0, 5) == 0) sr = ~sr;
      cyc(r1, r2, $urandom_range(0, 5) == 0, sr, 1);
    end
    cyc(0, 0, 0, 0, 2);
    cyc(0, 1, 0, 0, 3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("reset_mid_grant", {1'b0, g2[0]}, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 0, 0, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
